md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide unit for the Execute stage, holding the architectural HI/LO registers. Operands arrive already forwarded. The block runs a multi-cycle operation and raises `busy` so the hazard unit stalls dependent MD instructions. Unlike a write-at-issue design, results are held in a pending register and committed only when the latency counter expires. In-flight operations can be cancelled with `flush`, and optional multiply-accumulate is supported.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_LAT`, 5: busy cycles for multiply and accumulate operations. Must be ≥1.
- `DIV_LAT`, 10: busy cycles for divide operations. Must be ≥1.
- `clk`  in  1  clock; everything acts on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  issue `op` in this cycle.
- `op`  in  4  operation code, defined in `md_pkg`.
- `a`  in  WIDTH  operand rs, already forwarded.
- `b`  in  WIDTH  operand rt, already forwarded.
- `flush`  in  1  cancel the in-flight operation.
- `busy`  out  1  operation in flight. Registered. Resets to 0.
- `hi`  out  WIDTH  architectural HI. Resets to 0.
- `lo`  out  WIDTH  architectural LO. Resets to 0.
- `div_zero`  out  1  sticky until the next accepted start: the last committed divide had b==0. Resets to 0.

## Operation
- Opcodes:
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9.
  - Other codes are no-ops.
- Accept rule: `start` is accepted only when `busy`==0 and `flush`==0. Otherwise it is ignored with no state change. The hazard unit is responsible for holding the instruction.
- MTHI/MTLO:
  - `hi` (or `lo`) ← `a` at the accepting edge.
  - `busy` stays 0.
- MULT/MULTU:
  - {hi,lo} ← signed/unsigned 2·WIDTH-bit product of `a`·`b`.
- DIV/DIVU:
  - lo ← quotient, truncated toward zero; hi ← remainder, with the sign of the dividend.
  - Signed overflow (INT_MIN / −1): lo=INT_MIN, hi=0.
- Divide with b==0:
  - Still busy for DIV_LAT cycles.
  - hi/lo unchanged at commit; `div_zero`←1.
- MADD/MSUB (and unsigned forms):
  - {hi,lo} ← {hi,lo} ± product, modulo 2^(2·WIDTH).
  - {hi,lo} is sampled at accept time.
- The result is computed at accept and stored in the pending register (pend_hi, pend_lo, pend_dz). The counter loads the latency value.
- States:
  - IDLE: counter==0.
  - RUN: counter>0, decrements every cycle.
  - Transition RUN→IDLE when the counter reaches 0. On that edge the pending result is committed to hi/lo/div_zero.
- Flush:
  - If `flush`=1 while busy: counter←0 and the pending result is discarded. hi/lo unchanged; `busy`=0 next cycle.
  - Flush while idle: no effect.
  - Flush beats a simultaneous `start`.
- Reset mid-operation: counter, pending, hi, lo and div_zero clear immediately, without waiting for a clock edge.

## Timing
- Accept at the edge ending cycle T:
  - `busy`=1 during cycles T+1 … T+LAT.
  - New hi/lo are visible and `busy`=0 in cycle T+LAT+1.
- A new `start` can be accepted in cycle T+LAT+1 (back-to-back after completion).
- MTHI/MTLO: the value is visible in cycle T+1.
- Flush asserted in cycle F while busy: `busy`=0 in cycle F+1.
- `hi`/`lo` never expose pending values. During busy they hold the previously committed values.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).

## Configuration
- `MD_ACCUM_EN` defined: opcodes 6–9 are implemented as above.
- `MD_ACCUM_EN` undefined: opcodes 6–9 are no-ops (not accepted, `busy` stays 0), and the accumulate adder is absent.

## Structure
- `md_pkg` holds:
  - the opcode localparams (MD_MULT … MD_MSUBU);
  - the opcode width (4);
  - the helper functions is_mul/is_div/is_acc.
- Sub-module `md_compute`: purely combinational. Inputs: op, a, b, hi, lo. Outputs: res_hi, res_lo, dz. It covers the product, quotient/remainder, overflow case and accumulate.
- `md_unit` itself holds the counter, pending registers, HI/LO, and the flush/accept logic.

## Test plan
- MULT a=0xFFFFFFFE, b=3 → `busy` high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU a=7, b=2 → after 10 busy cycles lo=3, hi=1. DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI 0x11, MTLO 0x22, then DIV a=5, b=0 → busy for 10 cycles; hi=0x11, lo=0x22, `div_zero`=1.
- MULT a=2, b=3, then at cycle T+2 issue `start` DIVU (ignored) and at T+3 assert `flush` → `busy`=0 at T+4; hi/lo keep their prior values; no divide result ever appears.
- MD_ACCUM_EN defined: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0 after 5 cycles. Macro undefined: same stimulus → `busy` never rises and hi/lo unchanged.
- Drop `reset` to 0 mid-DIV with no clock edge → `busy`, hi, lo and `div_zero` go to 0 immediately. After reset is released, a MULT a=3, b=4 gives lo=12, hi=0.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: opcode encoding and opcode-class helpers for the multiply/divide unit.
package md_pkg;
    localparam int MD_OP_W = 4;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd8;
    localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd9;

    function automatic logic is_mul(input logic [MD_OP_W-1:0] op);
        return op == MD_MULT || op == MD_MULTU;
    endfunction

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

    function automatic logic is_acc(input logic [MD_OP_W-1:0] op);
        return op >= MD_MADD && op <= MD_MSUBU;
    endfunction
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational product, quotient/remainder, MTHI/MTLO and (with MD_ACCUM_EN) accumulate.
import md_pkg::*;

module md_compute #(
    parameter int WIDTH = 32
) (
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic               dz
);
    logic               sgn;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mag_a, mag_b, dvs, uq, ur, q, r;
`ifdef MD_ACCUM_EN
    logic [2*WIDTH-1:0] acc;
`endif

    assign sgn   = op == MD_MULT || op == MD_DIV || op == MD_MADD || op == MD_MSUB;
    // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
    assign prod  = sgn ? {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b}
                       : {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    // Magnitude divide; INT_MIN / -1 wraps naturally to lo=INT_MIN, hi=0.
    assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;
    assign dvs   = (b == '0) ? WIDTH'(1) : mag_b;
    assign uq    = mag_a / dvs;
    assign ur    = mag_a % dvs;
    assign q     = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -uq : uq;
    assign r     = (sgn && a[WIDTH-1]) ? -ur : ur;
`ifdef MD_ACCUM_EN
    assign acc   = (op == MD_MSUB || op == MD_MSUBU) ? {hi, lo} - prod : {hi, lo} + prod;
`endif

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        dz     = 1'b0;
        if (is_mul(op))
            {res_hi, res_lo} = prod;
        else if (is_div(op)) begin
            dz     = b == '0;
            res_hi = dz ? hi : r;
            res_lo = dz ? lo : q;
        end
        else if (op == MD_MTHI)
            res_hi = a;
        else if (op == MD_MTLO)
            res_lo = a;
`ifdef MD_ACCUM_EN
        else if (is_acc(op))
            {res_hi, res_lo} = acc;
`endif
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO; results commit when the latency counter expires.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MD_ACCUM_EN.
import md_pkg::*;

module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               div_zero
);
    localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo, res_hi, res_lo;
    logic             pend_dz, dz, acc_op, mt_op, run_op, accept;

`ifdef MD_ACCUM_EN
    assign acc_op = is_acc(op);
`else
    assign acc_op = 1'b0;
`endif
    assign mt_op  = op == MD_MTHI || op == MD_MTLO;
    assign run_op = is_mul(op) || is_div(op) || acc_op;
    assign accept = start && !busy && !flush && (run_op || mt_op);

    md_compute #(.WIDTH(WIDTH)) u_compute (
        .op(op), .a(a), .b(b), .hi(hi), .lo(lo),
        .res_hi(res_hi), .res_lo(res_lo), .dz(dz)
    );

    // busy mirrors (cnt != 0) but is kept as its own flop so the output is registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            busy     <= 1'b0;
            pend_hi  <= '0;
            pend_lo  <= '0;
            pend_dz  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (busy && flush) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy     <= 1'b0;
                hi       <= pend_hi;
                lo       <= pend_lo;
                div_zero <= pend_dz;
            end
        end else if (accept) begin
            div_zero <= 1'b0;
            if (mt_op) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                cnt     <= is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                busy    <= 1'b1;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_dz <= dz;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit (default latencies 5/10, WIDTH 32).
import md_pkg::*;

module tb_md_unit;
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic [MD_OP_W-1:0] op = '0;
    logic [31:0]        a = '0;
    logic [31:0]        b = '0;
    logic               busy, div_zero;
    logic [31:0]        hi, lo;
    int                 n_cmp = 0;
    int                 n_bad = 0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic [MD_OP_W-1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_busy(input string tag, input int lat);
        for (int i = 0; i < lat; i++) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hidden", {hi, lo}, 64'd0);
        run_busy("mult", 5);
        chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        issue(MD_DIVU, 32'd7, 32'd2);
        run_busy("divu", 10);
        chk("divu_res", {hi, lo}, {32'd1, 32'd3});

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        run_busy("div", 10);
        chk("div_res", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_busy("div_ovf", 10);
        chk("div_ovf_res", {hi, lo}, {32'd0, 32'h8000_0000});

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_busy("multu", 5);
        chk("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(MD_MTHI, 32'h11, 32'd0);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_val", {hi, lo}, {32'h11, 32'h0000_0001});
        issue(MD_MTLO, 32'h22, 32'd0);
        chk("mtlo_val", {hi, lo}, {32'h11, 32'h22});
        issue(MD_DIV, 32'd5, 32'd0);
        run_busy("div0", 10);
        chk("div0_hilo", {hi, lo}, {32'h11, 32'h22});
        chk("div0_dz", 64'(div_zero), 64'd1);

        // MULT, ignored DIVU while busy, then flush discards everything
        issue(MD_MULT, 32'd2, 32'd3);
        chk("fl_busy1", 64'(busy), 64'd1);
        chk("fl_dz_clr", 64'(div_zero), 64'd0);
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy0", 64'(busy), 64'd0);
        chk("fl_hilo", {hi, lo}, {32'h11, 32'h22});
        repeat (12) @(negedge clk);
        chk("fl_late_busy", 64'(busy), 64'd0);
        chk("fl_late_hilo", {hi, lo}, {32'h11, 32'h22});

        // flush wins over a simultaneous start
        start = 1'b1; flush = 1'b1; op = MD_MTHI; a = 32'h99;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("fl_vs_start", {hi, lo}, {32'h11, 32'h22});

        issue(MD_MTHI, 32'd0, 32'd0);
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_ACCUM_EN
        run_busy("maddu", 5);
        chk("maddu_res", {hi, lo}, {32'd1, 32'd0});
        issue(MD_MSUB, 32'd2, 32'd3);
        run_busy("msub", 5);
        chk("msub_res", {hi, lo}, {32'd0, 32'hFFFF_FFFA});
`else
        for (int i = 0; i < 6; i++) begin
            chk("maddu_nobusy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        chk("maddu_noop", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

        // asynchronous reset in the middle of a divide
        issue(MD_MTHI, 32'h55, 32'd0);
        issue(MD_DIV, 32'd9, 32'd2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        chk("arst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(MD_MULT, 32'd3, 32'd4);
        run_busy("post_rst", 5);
        chk("post_rst_res", {hi, lo}, {32'd0, 32'd12});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
